uart_rx_ctrl: RTL and testbench

Receive-path sequencer for the UART RX. It owns the per-bit edge counter and the frame bit counter. It drives the sampler enable, the deserializer write strobe and bit index, and the start/parity/stop check strobes. It qualifies each received frame with a one-cycle `data_valid` or `frame_err` pulse. It sits between the oversampled `RX_IN` line and the sampler, deserializer and check blocks.

---
 rtl/uart_rx_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//
// Receive-path sequencer for the UART RX. It tracks the edge position inside
// each bit and the bit position inside the frame. From these it raises the
// sampler enable, the deserializer write strobe and the start/parity/stop check
// strobes. Each frame ends with a one-cycle data_valid or frame_err pulse.
//
// Build option:
//   UART_RX_PARITY_EN  - when defined, a PARITY bit follows the data bits
//                        whenever PAR_EN is high at frame start. When
//                        undefined, PAR_EN and par_err are ignored and
//                        par_chk_en is held at 0.
//
// Ports:
//   CLK          in   oversampling clock
//   RST          in   asynchronous active-low reset
//   RX_IN        in   synchronized serial line, idle high
//   PAR_EN       in   frame carries a parity bit (parity builds only)
//   Prescale     in   clock edges per bit; clamped to >= 8 and forced even
//   strt_glitch  in   start checker result, sampled while strt_chk_en is high
//   par_err      in   parity checker result, sampled while par_chk_en is high
//   stp_err      in   stop checker result, sampled while stp_chk_en is high
//   dat_samp_en  out  sampler enable, high in every non-IDLE state
//   edge_cnt     out  edge index inside the current bit
//   bit_cnt      out  bit index: start 0, data 1..DATA_WIDTH, then parity/stop
//   deser_en     out  deserializer write strobe (writes position bit_cnt-1)
//   strt_chk_en  out  start check strobe
//   par_chk_en   out  parity check strobe
//   stp_chk_en   out  stop check strobe
//   data_valid   out  one-cycle pulse, frame received without error
//   frame_err    out  one-cycle pulse, frame ended with parity or stop error
//   fsm_state    out  current state encoding (0 IDLE, 1 START, 2 DATA,
//                     3 PARITY, 4 STOP), for observation
//
// All strobes are registered and high for exactly one cycle, in the cycle
// where edge_cnt equals the check edge C = P/2 + 2, P being the prescale
// latched at frame start.
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic [PRESCALE_W-1:0] Prescale,
   input  logic                  strt_glitch,
   input  logic                  par_err,
   input  logic                  stp_err,
   output logic                  dat_samp_en,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic [3:0]            bit_cnt,
   output logic                  deser_en,
   output logic                  strt_chk_en,
   output logic                  par_chk_en,
   output logic                  stp_chk_en,
   output logic                  data_valid,
   output logic                  frame_err,
   output logic [2:0]            fsm_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   localparam logic [PRESCALE_W-1:0] P_MIN     = PRESCALE_W'(8);
   localparam logic [PRESCALE_W-1:0] ONE       = PRESCALE_W'(1);
   localparam logic [PRESCALE_W-1:0] TWO       = PRESCALE_W'(2);
   localparam logic [3:0]            LAST_DATA = 4'(DATA_WIDTH);

   state_t                state_q;
   state_t                state_nxt;
   logic [PRESCALE_W-1:0] edge_nxt;
   logic [3:0]            bit_nxt;
   logic [PRESCALE_W-1:0] p_q;
   logic [PRESCALE_W-1:0] p_nxt;
   logic [PRESCALE_W-1:0] p_clamped;
   logic [PRESCALE_W-1:0] c_nxt;
   logic                  par_act_q;
   logic                  par_act_nxt;
   logic                  par_flag_q;
   logic                  par_flag_nxt;
   logic                  edge_last;
   logic                  armed;
   logic                  par_en_gated;
   logic                  par_hit;

   logic                  deser_d;
   logic                  strt_d;
   logic                  par_d;
   logic                  stp_d;
   logic                  dv_d;
   logic                  fe_d;
   logic                  stop_done;
   logic                  err_any;
   logic                  at_check;

`ifdef UART_RX_PARITY_EN
   assign par_en_gated = PAR_EN;
   assign par_hit      = par_chk_en & par_err;
`else
   logic unused_par_inputs;
   assign par_en_gated      = 1'b0;
   assign par_hit           = 1'b0;
   assign unused_par_inputs = PAR_EN ^ par_err;
`endif

   // Clamp to the minimum ratio, then force even so C lands on a whole edge.
   always_comb begin
      p_clamped    = (Prescale < P_MIN) ? P_MIN : Prescale;
      p_clamped[0] = 1'b0;
   end

   assign edge_last = (edge_cnt == (p_q - ONE));

   // The end-of-frame pulse cycle is already IDLE; a start edge is only
   // accepted from the following cycle.
   assign armed = ~(data_valid | frame_err);

   // -------------------------------------------------------------------------
   // State register (with counters and per-frame latches)
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= S_IDLE;
         edge_cnt   <= '0;
         bit_cnt    <= '0;
         p_q        <= '0;
         par_act_q  <= 1'b0;
         par_flag_q <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         edge_cnt   <= edge_nxt;
         bit_cnt    <= bit_nxt;
         p_q        <= p_nxt;
         par_act_q  <= par_act_nxt;
         par_flag_q <= par_flag_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_nxt    = state_q;
      edge_nxt     = edge_cnt;
      bit_nxt      = bit_cnt;
      p_nxt        = p_q;
      par_act_nxt  = par_act_q;
      par_flag_nxt = par_flag_q | par_hit;

      // Edge/bit counting common to all non-IDLE states.
      if (state_q != S_IDLE) begin
         if (edge_last) begin
            edge_nxt = '0;
            bit_nxt  = bit_cnt + 4'd1;
         end else begin
            edge_nxt = edge_cnt + ONE;
         end
      end

      case (state_q)
         S_IDLE: begin
            edge_nxt = '0;
            bit_nxt  = '0;
            if (!RX_IN && armed) begin
               state_nxt    = S_START;
               p_nxt        = p_clamped;
               par_act_nxt  = par_en_gated;
               par_flag_nxt = 1'b0;
            end
         end
         S_START: begin
            if (strt_chk_en && strt_glitch) begin
               state_nxt = S_IDLE;
               edge_nxt  = '0;
               bit_nxt   = '0;
            end else if (edge_last) begin
               state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (edge_last && (bit_cnt == LAST_DATA)) begin
               state_nxt = par_act_q ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (edge_last) begin
               state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            // Leave right after the stop check instead of waiting out the bit,
            // so a following start edge is never missed.
            if (stp_chk_en) begin
               state_nxt = S_IDLE;
               edge_nxt  = '0;
               bit_nxt   = '0;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            edge_nxt  = '0;
            bit_nxt   = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Output logic: strobes are derived from next-cycle state/counters and
   // registered, so they line up with edge_cnt == C.
   // -------------------------------------------------------------------------
   always_comb begin
      c_nxt     = (p_nxt >> 1) + TWO;
      at_check  = (edge_nxt == c_nxt);
      strt_d    = (state_nxt == S_START) && at_check;
      deser_d   = (state_nxt == S_DATA) && at_check;
`ifdef UART_RX_PARITY_EN
      par_d     = (state_nxt == S_PARITY) && at_check;
`else
      par_d     = 1'b0;
`endif
      stp_d     = (state_nxt == S_STOP) && at_check;
      stop_done = (state_q == S_STOP) && stp_chk_en;
      err_any   = par_flag_q | stp_err;
      dv_d      = stop_done & ~err_any;
      fe_d      = stop_done & err_any;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         deser_en    <= 1'b0;
         strt_chk_en <= 1'b0;
         par_chk_en  <= 1'b0;
         stp_chk_en  <= 1'b0;
         data_valid  <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         deser_en    <= deser_d;
         strt_chk_en <= strt_d;
         par_chk_en  <= par_d;
         stp_chk_en  <= stp_d;
         data_valid  <= dv_d;
         frame_err   <= fe_d;
      end
   end

   assign dat_samp_en = (state_q != S_IDLE);
   assign fsm_state   = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
//
// Directed bench for uart_rx_ctrl. Cycle k of a frame is the k-th cycle
// counted from the first cycle where RX_IN is low (k = 0). Outputs are read on
// the falling clock edge; inputs are changed right after reading, so checker
// responses land in the same cycle as their strobe.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;
   localparam int PW = 6;

   logic          CLK = 1'b0;
   logic          RST;
   logic          RX_IN;
   logic          PAR_EN;
   logic [PW-1:0] Prescale;
   logic          strt_glitch;
   logic          par_err;
   logic          stp_err;
   logic          dat_samp_en;
   logic [PW-1:0] edge_cnt;
   logic [3:0]    bit_cnt;
   logic          deser_en;
   logic          strt_chk_en;
   logic          par_chk_en;
   logic          stp_chk_en;
   logic          data_valid;
   logic          frame_err;
   logic [2:0]    fsm_state;

   int checks = 0;
   int errors = 0;

   // Event records filled while a frame runs.
   int n_deser, n_strt, n_par, n_stp, n_dv, n_fe, n_both, n_start;
   int deser_bit[32], deser_edge[32], deser_cyc[32];
   int dv_cyc[4], start_cyc[4], start_edge[4];
   int strt_cyc, strt_edge, par_cyc, par_edge, par_bit, stp_cyc, stp_bit, fe_cyc;
   int idle_cyc, samp_first, samp_last;
   logic [2:0] prev_state;

   uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(PW)) dut (
      .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
      .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
      .dat_samp_en(dat_samp_en), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
      .deser_en(deser_en), .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
      .stp_chk_en(stp_chk_en), .data_valid(data_valid), .frame_err(frame_err),
      .fsm_state(fsm_state)
   );

   // ---------------- clock ----------------
   always #5 CLK = ~CLK;

   // ---------------- driver / recorder tasks ----------------
   task automatic clear_rec();
      n_deser = 0; n_strt = 0; n_par = 0; n_stp = 0; n_dv = 0; n_fe = 0;
      n_both = 0; n_start = 0;
      strt_cyc = -1; strt_edge = -1; par_cyc = -1; par_edge = -1; par_bit = -1;
      stp_cyc = -1; stp_bit = -1; fe_cyc = -1; idle_cyc = -1;
      samp_first = -1; samp_last = -1;
      prev_state = fsm_state;
   endtask

   task automatic record(input int k);
      if (deser_en) begin
         if (n_deser < 32) begin
            deser_bit[n_deser]  = int'(bit_cnt);
            deser_edge[n_deser] = int'(edge_cnt);
            deser_cyc[n_deser]  = k;
         end
         n_deser++;
      end
      if (strt_chk_en) begin n_strt++; strt_cyc = k; strt_edge = int'(edge_cnt); end
      if (par_chk_en) begin
         n_par++; par_cyc = k; par_edge = int'(edge_cnt); par_bit = int'(bit_cnt);
      end
      if (stp_chk_en) begin n_stp++; stp_cyc = k; stp_bit = int'(bit_cnt); end
      if (data_valid) begin if (n_dv < 4) dv_cyc[n_dv] = k; n_dv++; end
      if (frame_err) begin n_fe++; fe_cyc = k; end
      if (data_valid && frame_err) n_both++;
      if (fsm_state == 3'd1 && prev_state == 3'd0) begin
         if (n_start < 4) begin start_cyc[n_start] = k; start_edge[n_start] = int'(edge_cnt); end
         n_start++;
      end
      if (fsm_state == 3'd0 && prev_state != 3'd0 && idle_cyc < 0) idle_cyc = k;
      if (dat_samp_en) begin if (samp_first < 0) samp_first = k; samp_last = k; end
      prev_state = fsm_state;
   endtask

   // Line level for bit idx of a frame: start 0, data LSB first, then high.
   function automatic logic line_bit(input logic [7:0] d, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
      return 1'b1;
   endfunction

   task automatic idle(input int n);
      RX_IN = 1'b1; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
      repeat (n) @(negedge CLK);
   endtask

   // Drives one frame (optionally a second starting at cycle s1) and records
   // every strobe. pl: line cycles per bit, nb: line bits per frame.
   task automatic run(input logic [7:0] d0, input logic [7:0] d1, input bit two,
                      input int s1, input int pl, input int nb,
                      input logic [PW-1:0] pre0, input int chg, input logic [PW-1:0] pre1,
                      input bit pen, input bit glitch, input int low_len,
                      input bit perr, input bit serr, input int ncyc);
      logic l;
      clear_rec();
      Prescale = pre0;
      PAR_EN   = pen;
      for (int k = 0; k < ncyc; k++) begin
         @(negedge CLK);
         record(k);
         if (k == chg) Prescale = pre1;
         l = 1'b1;
         if (glitch) begin
            l = (k < low_len) ? 1'b0 : 1'b1;
         end else begin
            if (k < nb * pl) l = line_bit(d0, k / pl);
            if (two && k >= s1 && k < s1 + nb * pl) l = line_bit(d1, (k - s1) / pl);
         end
         RX_IN       = l;
         strt_glitch = glitch & strt_chk_en;
         par_err     = perr & par_chk_en;
         stp_err     = serr & stp_chk_en;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = PW'(8);
      strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
      repeat (3) @(negedge CLK);
      checks++;
      if ({dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, frame_err} !== 7'b0) begin
         errors++; $display("FAIL reset_strobes got %b want 0000000",
            {dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, frame_err});
      end
      checks++;
      if (edge_cnt !== '0 || bit_cnt !== 4'd0) begin
         errors++; $display("FAIL reset_counters got edge %0d bit %0d want 0 0", edge_cnt, bit_cnt);
      end
      checks++;
      if (fsm_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", fsm_state); end
      RST = 1'b1;
      repeat (4) @(negedge CLK);
      checks++;
      if (fsm_state !== 3'd0 || dat_samp_en !== 1'b0) begin
         errors++; $display("FAIL reset_idle_hold got state %0d samp %0d want 0 0", fsm_state, dat_samp_en);
      end
   endtask

   task automatic test_clean_frame();
      run(8'hA5, 8'h00, 1'b0, 0, 8, 10, PW'(8), -1, PW'(8), 1'b0, 1'b0, 0, 1'b0, 1'b0, 90);
      checks++; if (n_deser !== 8) begin errors++; $display("FAIL clean_deser_count got %0d want 8", n_deser); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (deser_bit[i] !== i + 1 || deser_edge[i] !== 6 || deser_cyc[i] !== 15 + 8 * i) begin
            errors++; $display("FAIL clean_deser_%0d got bit %0d edge %0d cyc %0d want %0d 6 %0d",
               i, deser_bit[i], deser_edge[i], deser_cyc[i], i + 1, 15 + 8 * i);
         end
      end
      checks++;
      if (n_strt !== 1 || strt_cyc !== 7 || strt_edge !== 6) begin
         errors++; $display("FAIL clean_strt got n %0d cyc %0d edge %0d want 1 7 6", n_strt, strt_cyc, strt_edge);
      end
      checks++;
      if (n_stp !== 1 || stp_cyc !== 79 || stp_bit !== 9) begin
         errors++; $display("FAIL clean_stp got n %0d cyc %0d bit %0d want 1 79 9", n_stp, stp_cyc, stp_bit);
      end
      checks++;
      if (n_dv !== 1 || dv_cyc[0] !== 80) begin
         errors++; $display("FAIL clean_dv got n %0d cyc %0d want 1 80", n_dv, dv_cyc[0]);
      end
      checks++; if (n_fe !== 0) begin errors++; $display("FAIL clean_fe got %0d want 0", n_fe); end
      checks++; if (n_par !== 0) begin errors++; $display("FAIL clean_par got %0d want 0", n_par); end
      checks++;
      if (samp_first !== 1 || samp_last !== 79) begin
         errors++; $display("FAIL clean_samp_window got %0d..%0d want 1..79", samp_first, samp_last);
      end
      checks++;
      if (idle_cyc !== 80) begin errors++; $display("FAIL clean_idle_return got %0d want 80", idle_cyc); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      run(8'h96, 8'h00, 1'b0, 0, 16, 11, PW'(16), -1, PW'(16), 1'b1, 1'b0, 0, 1'b1, 1'b0, 185);
      checks++;
      if (n_par !== 1 || par_bit !== 9 || par_edge !== 10 || par_cyc !== 155) begin
         errors++; $display("FAIL parity_strobe got n %0d bit %0d edge %0d cyc %0d want 1 9 10 155",
            n_par, par_bit, par_edge, par_cyc);
      end
      checks++;
      if (n_stp !== 1 || stp_bit !== 10 || stp_cyc !== 171) begin
         errors++; $display("FAIL parity_stp got n %0d bit %0d cyc %0d want 1 10 171", n_stp, stp_bit, stp_cyc);
      end
      checks++;
      if (n_fe !== 1 || fe_cyc !== 172) begin
         errors++; $display("FAIL parity_fe got n %0d cyc %0d want 1 172", n_fe, fe_cyc);
      end
      checks++; if (n_dv !== 0) begin errors++; $display("FAIL parity_dv got %0d want 0", n_dv); end
      checks++; if (n_deser !== 8) begin errors++; $display("FAIL parity_deser got %0d want 8", n_deser); end
   endtask
`else
   task automatic test_parity();
      // Parity request and error are ignored in this build.
      run(8'h96, 8'h00, 1'b0, 0, 16, 10, PW'(16), -1, PW'(16), 1'b1, 1'b0, 0, 1'b1, 1'b0, 170);
      checks++; if (n_par !== 0) begin errors++; $display("FAIL noparity_strobe got %0d want 0", n_par); end
      checks++;
      if (n_stp !== 1 || stp_bit !== 9 || stp_cyc !== 155) begin
         errors++; $display("FAIL noparity_stp got n %0d bit %0d cyc %0d want 1 9 155", n_stp, stp_bit, stp_cyc);
      end
      checks++;
      if (n_dv !== 1 || dv_cyc[0] !== 156) begin
         errors++; $display("FAIL noparity_dv got n %0d cyc %0d want 1 156", n_dv, dv_cyc[0]);
      end
      checks++; if (n_fe !== 0) begin errors++; $display("FAIL noparity_fe got %0d want 0", n_fe); end
   endtask
`endif

   task automatic test_stop_err();
      run(8'h00, 8'h00, 1'b0, 0, 8, 10, PW'(8), -1, PW'(8), 1'b0, 1'b0, 0, 1'b0, 1'b1, 90);
      checks++;
      if (n_fe !== 1 || fe_cyc !== 80) begin
         errors++; $display("FAIL stop_err_fe got n %0d cyc %0d want 1 80", n_fe, fe_cyc);
      end
      checks++; if (n_dv !== 0) begin errors++; $display("FAIL stop_err_dv got %0d want 0", n_dv); end
   endtask

   task automatic test_glitch();
      run(8'hFF, 8'h00, 1'b0, 0, 8, 10, PW'(8), -1, PW'(8), 1'b0, 1'b1, 3, 1'b0, 1'b0, 40);
      checks++;
      if (n_strt !== 1 || strt_cyc !== 7) begin
         errors++; $display("FAIL glitch_strt got n %0d cyc %0d want 1 7", n_strt, strt_cyc);
      end
      checks++;
      if (idle_cyc !== 8) begin errors++; $display("FAIL glitch_idle got %0d want 8", idle_cyc); end
      checks++;
      if (n_deser !== 0 || n_dv !== 0 || n_fe !== 0 || n_stp !== 0) begin
         errors++; $display("FAIL glitch_quiet got deser %0d dv %0d fe %0d stp %0d want 0 0 0 0",
            n_deser, n_dv, n_fe, n_stp);
      end
   endtask

   task automatic test_back_to_back();
      run(8'h3C, 8'hC3, 1'b1, 81, 8, 10, PW'(8), -1, PW'(8), 1'b0, 1'b0, 0, 1'b0, 1'b0, 175);
      checks++;
      if (n_dv !== 2 || dv_cyc[0] !== 80 || dv_cyc[1] !== 161) begin
         errors++; $display("FAIL b2b_dv got n %0d cyc %0d %0d want 2 80 161", n_dv, dv_cyc[0], dv_cyc[1]);
      end
      checks++; if (n_deser !== 16) begin errors++; $display("FAIL b2b_deser got %0d want 16", n_deser); end
      checks++;
      if (n_start !== 2 || start_cyc[1] !== 82 || start_edge[1] !== 0) begin
         errors++; $display("FAIL b2b_second_start got n %0d cyc %0d edge %0d want 2 82 0",
            n_start, start_cyc[1], start_edge[1]);
      end
      checks++;
      if (n_fe !== 0 || n_both !== 0) begin
         errors++; $display("FAIL b2b_fe got fe %0d both %0d want 0 0", n_fe, n_both);
      end
   endtask

   task automatic test_reset_mid_data();
      int bad;
      PAR_EN = 1'b0; Prescale = PW'(8);
      for (int k = 0; k < 40; k++) begin
         @(negedge CLK);
         RX_IN = line_bit(8'hFF, k / 8);
      end
      @(negedge CLK);
      // Cycle 40 of the frame: bit 4 ends at edge 7 (bit 4 spans cycles 33..40).
      checks++;
      if (bit_cnt !== 4'd4 || edge_cnt !== PW'(7) || fsm_state !== 3'd2) begin
         errors++; $display("FAIL rst_pre got bit %0d edge %0d state %0d want 4 7 2", bit_cnt, edge_cnt, fsm_state);
      end
      RST = 1'b0;
      #1;
      checks++;
      if ({dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, frame_err} !== 7'b0
          || edge_cnt !== '0 || bit_cnt !== 4'd0 || fsm_state !== 3'd0) begin
         errors++; $display("FAIL rst_async got samp %0d edge %0d bit %0d state %0d want all 0",
            dat_samp_en, edge_cnt, bit_cnt, fsm_state);
      end
      @(negedge CLK);
      RST = 1'b1; RX_IN = 1'b1;
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         if (fsm_state !== 3'd0 || dat_samp_en !== 1'b0 || data_valid !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL rst_idle_after got %0d busy cycles want 0", bad); end
      RX_IN = 1'b0;
      @(negedge CLK);
      checks++;
      if (fsm_state !== 3'd1 || edge_cnt !== '0) begin
         errors++; $display("FAIL rst_restart got state %0d edge %0d want 1 0", fsm_state, edge_cnt);
      end
      RX_IN = 1'b1;
      idle(90);
   endtask

   task automatic test_prescale_clamp();
      run(8'h5A, 8'h00, 1'b0, 0, 8, 10, PW'(5), 20, PW'(16), 1'b0, 1'b0, 0, 1'b0, 1'b0, 90);
      checks++; if (n_deser !== 8) begin errors++; $display("FAIL clamp_deser_count got %0d want 8", n_deser); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (deser_edge[i] !== 6 || deser_cyc[i] !== 15 + 8 * i) begin
            errors++; $display("FAIL clamp_deser_%0d got edge %0d cyc %0d want 6 %0d",
               i, deser_edge[i], deser_cyc[i], 15 + 8 * i);
         end
      end
      checks++;
      if (n_dv !== 1 || dv_cyc[0] !== 80) begin
         errors++; $display("FAIL clamp_dv got n %0d cyc %0d want 1 80", n_dv, dv_cyc[0]);
      end
      checks++;
      if (strt_edge !== 6 || stp_cyc !== 79) begin
         errors++; $display("FAIL clamp_strobes got strt edge %0d stp cyc %0d want 6 79", strt_edge, stp_cyc);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      idle(4);
      test_clean_frame();
      idle(4);
      test_parity();
      idle(4);
      test_stop_err();
      idle(4);
      test_glitch();
      idle(4);
      test_back_to_back();
      idle(4);
      test_reset_mid_data();
      idle(4);
      test_prescale_clamp();
      idle(4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
